// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller.
// One shared nibble decoder is time-shared across NUM_DIGITS common-anode
// digits. Each digit slot is REFRESH_DIV cycles: a SHOW phase, then
// BLANK_CYCLES of all-off ghost blanking. Display data is double-buffered
// (pend -> disp) and only swapped at the frame boundary, so a frame never tears.

// Per-digit leading-zero chain element: a digit is "zero from here up" when
// its own nibble is zero and every more-significant digit is too.
module seg_scan_lane (
  input  logic [3:0] nib_i,
  input  logic       zero_above_i,
  output logic       zero_o
);
  assign zero_o = zero_above_i && (nib_i == 4'd0);
endmodule

module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 270
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] IN_DATA,
  input  logic                    IN_LOAD,
  input  logic                    IN_LZ_EN,
  output logic [3:0]              OUT_NIBBLE,
  output logic [NUM_DIGITS-1:0]   OUT_DIG,
  output logic                    OUT_FRAME
);

  localparam int CW = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
  localparam int IW = ($clog2(NUM_DIGITS)  < 1) ? 1 : $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] CNT_MAX  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] SHOW_LEN = CW'(REFRESH_DIV - BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} phase_e;

  typedef logic [NUM_DIGITS-1:0][3:0] nibs_t;

  // State
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic [IW-1:0]         idx_q,   idx_d;
  nibs_t                 pend_q,  pend_d;
  nibs_t                 disp_q,  disp_d;
  phase_e                phase_q, phase_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0] dig_q,   dig_d;
  logic [3:0]            nib_q,   nib_d;
  logic                  frame_q, frame_d;

  logic                  slot_wrap, frame_wrap, sup;
  logic [NUM_DIGITS:0]   zero_up;

  // Leading-zero chain, evaluated on the display data the next cycle will use.
  assign zero_up[NUM_DIGITS] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
      seg_scan_lane u_lane (
        .nib_i        (disp_d[g]),
        .zero_above_i (zero_up[g+1]),
        .zero_o       (zero_up[g])
      );
    end
  endgenerate

  // Slot/frame sequencing and the SHOW/BLANK phase transitions.
  always_comb begin
    slot_wrap  = (cnt_q == CNT_MAX);
    frame_wrap = slot_wrap && (idx_q == IDX_MAX);
    cnt_d      = slot_wrap ? '0 : cnt_q + 1'b1;
    if (frame_wrap)     idx_d = '0;
    else if (slot_wrap) idx_d = idx_q + 1'b1;
    else                idx_d = idx_q;

    // A load coinciding with the frame boundary lands straight in disp.
    pend_d = IN_LOAD ? nibs_t'(IN_DATA) : pend_q;
    disp_d = frame_wrap ? pend_d : disp_q;

    phase_d = phase_q;
    if (slot_wrap)              phase_d = SHOW;
    else if (cnt_d == SHOW_LEN) phase_d = BLANK;
  end

  // Output decode from the next state, so registered outputs track state.
  always_comb begin
    dig_d   = '1;
    nib_d   = '0;
    sup     = 1'b0;
    frame_d = (cnt_d == '0) && (idx_d == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        // Digit 0 always shows, even when the whole value is zero.
        sup = IN_LZ_EN && zero_up[i] && (i != 0);
        if ((phase_d == SHOW) && !sup) begin
          dig_d[i] = 1'b0;
          nib_d    = disp_d[i];
        end
      end
    end
  end

  // Single state register with synchronous reset; outputs blanked in reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      phase_q <= SHOW;
      dig_q   <= '1;
      nib_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      phase_q <= phase_d;
      dig_q   <= dig_d;
      nib_q   <= nib_d;
      frame_q <= frame_d;
    end
  end

  assign OUT_DIG    = dig_q;
  assign OUT_NIBBLE = nib_q;
  assign OUT_FRAME  = frame_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Multiplexed 7-segment scan controller for the adder display board.
- Time-shares the single nibble-to-segment decoder across NUM_DIGITS common-anode digits, one digit at a time.
- Drives the decoder input nibble and the active-low digit enables; the decoder's active-low segment outputs go straight to the pins.
- Provides inter-digit ghost blanking, tear-free frame-synchronous data update and optional leading-zero suppression.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal 2..8.
- REFRESH_DIV, 27000: CLK cycles per digit slot (27 MHz gives a 1 kHz slot). Must be >= 2.
- BLANK_CYCLES, 270: cycles at the end of each slot with all digits off. Must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, synchronous, active-high.
- IN_DATA  in  4*NUM_DIGITS  nibble per digit; bits [4i+3:4i] are digit i; digit 0 is least significant/rightmost.
- IN_LOAD  in  1  single-cycle strobe; captures IN_DATA into the pending register.
- IN_LZ_EN  in  1  leading-zero suppression enable, sampled live.
- OUT_NIBBLE  out  4  to decoder IN_A..IN_D; bit 3 drives IN_A.
- OUT_DIG  out  NUM_DIGITS  digit enables, active-low; at most one bit low at any time.
- OUT_FRAME  out  1  one-cycle pulse at each frame start.

Behaviour:
- Single clock domain; reset is synchronous and active-high; all outputs are registered.
- State: slot counter cnt (0..REFRESH_DIV-1), digit index idx (0..NUM_DIGITS-1), pending register pend, display register disp.
- Two-phase slot FSM:
  - SHOW while cnt < REFRESH_DIV-BLANK_CYCLES.
  - BLANK for the remaining cycles.
- Advance rules:
  - Each non-reset edge: cnt increments.
  - At cnt == REFRESH_DIV-1: cnt -> 0 and idx -> idx+1, wrapping NUM_DIGITS-1 -> 0.
  - On wrap to 0: disp <= pend (frame boundary).
- Output update: on each non-reset edge the outputs are loaded from the decode of the new state, so outputs always match current state.
  - SHOW, digit not suppressed: OUT_DIG = all 1s except bit idx = 0; OUT_NIBBLE = disp nibble idx.
  - BLANK, or digit suppressed: OUT_DIG = all 1s; OUT_NIBBLE = 0.
  - OUT_FRAME = 1 exactly in the first cycle of slot idx=0; 0 otherwise.
- Leading-zero suppression, when IN_LZ_EN=1:
  - Digit i (i >= 1) is suppressed if disp nibbles i..NUM_DIGITS-1 are all zero.
  - Digit 0 is never suppressed.
  - Suppressed slots keep full timing; the scan never skips or shortens a slot.
- Load handling:
  - IN_LOAD=1 writes pend <= IN_DATA in any cycle.
  - Multiple loads within one frame: the last one wins.
  - Load in the same cycle as the frame boundary: IN_DATA goes directly to disp (and pend).
  - disp never changes mid-frame.
- Reset (RST=1 at an edge, any time including mid-slot):
  - State: cnt=0, idx=0, pend=0, disp=0.
  - Outputs: OUT_DIG all 1s, OUT_NIBBLE=0, OUT_FRAME=0.
  - The first non-reset edge moves to cnt=1, so the first slot after reset shows one cycle less. No OUT_FRAME pulse is generated for this first partial frame.
- Arithmetic: cnt width is clog2(REFRESH_DIV) and idx width is clog2(NUM_DIGITS), minimum 1. Wrap is by compare, not by overflow, so non-power-of-two values are legal.

Test Plan:
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 (6 show + 2 blank per slot, 32-cycle frame).
- Reset: RST high 3 cycles -> OUT_DIG=4'b1111, OUT_NIBBLE=0, OUT_FRAME=0 throughout. After release, 5 cycles of OUT_DIG=1110 / OUT_NIBBLE=0, then 2 cycles of 1111.
- Scan order: IN_LOAD with IN_DATA=16'h1234, IN_LZ_EN=0; next frame:
  - OUT_NIBBLE 4,3,2,1 for 6 cycles each.
  - OUT_DIG 1110, 1101, 1011, 0111 respectively.
  - OUT_DIG=1111 for 2 cycles between each slot.
  - OUT_FRAME pulses every 32 cycles, on the first cycle of OUT_DIG=1110.
- Leading-zero suppression: IN_DATA=16'h0070, IN_LZ_EN=1:
  - Digits 3 and 2 show OUT_DIG=1111 for their whole slot.
  - Digit 1 shows 7; digit 0 shows 0.
  - IN_DATA=16'h0000 -> only digit 0 active, showing 0.
  - IN_DATA=16'h0700 -> digit 1 shows 0 (not suppressed).
- Tear-free update: load 16'h1234, then load 16'hABCD during the digit-1 slot:
  - Remainder of the frame shows 2, 1.
  - Next frame shows D, C, B, A.
  - A load asserted exactly at the frame-boundary cycle is displayed in the frame that starts there.
- Last-load-wins: loads of 16'h1111 then 16'h2222 in the same frame -> next frame shows 2,2,2,2.
- Mid-frame reset: assert RST during the digit-2 SHOW phase:
  - Next cycle OUT_DIG=1111, OUT_NIBBLE=0.
  - After release, digit 0 shows 0 (disp cleared) until a new load reaches a frame boundary.
